// File: rtl/md_burst_sequencer_pkg.sv
// Burst sequencer shared types and default widths.
// FSM state encoding used by the top level.
package md_pkg;

  localparam int MD_DW      = 512;
  localparam int MD_BEAT_W  = 16;
  localparam int MD_FRAME_W = 16;
  localparam int MD_GAP_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/md_burst_sequencer_frame_counter.sv
// Beat, frame and gap counters for the burst sequencer.
// Holds the latched burst config and exposes boundary flags.
module md_frame_counter
  import md_pkg::*;
#(
  parameter int BEAT_W  = MD_BEAT_W,
  parameter int FRAME_W = MD_FRAME_W,
  parameter int GAP_W   = MD_GAP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               beat,
  input  logic               gap_load,
  input  logic               gap_dec,
  input  logic [BEAT_W-1:0]  cfg_beats,
  input  logic [FRAME_W-1:0] cfg_frames,
  input  logic [GAP_W-1:0]   cfg_gap,
  output logic [FRAME_W-1:0] frames_sent,
  output logic               beat_last,
  output logic               frame_last,
  output logic               gap_last,
  output logic               gap_zero
);

  logic [BEAT_W-1:0]  beats_q;
  logic [FRAME_W-1:0] frames_q;
  logic [GAP_W-1:0]   gap_q;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  assign beat_last  = (beat_cnt == beats_q - 1'b1);
  assign frame_last = (frames_sent == frames_q - 1'b1);
  assign gap_last   = (gap_cnt == GAP_W'(1));
  assign gap_zero   = (gap_q == '0);

  // Config snapshot, taken only when a burst is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q  <= '0;
      frames_q <= '0;
      gap_q    <= '0;
    end else if (load) begin
      beats_q  <= cfg_beats;
      frames_q <= cfg_frames;
      gap_q    <= cfg_gap;
    end
  end

  // Beat position, completed frames and remaining gap cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      frames_sent <= '0;
      gap_cnt     <= '0;
    end else if (load) begin
      beat_cnt    <= '0;
      frames_sent <= '0;
      gap_cnt     <= '0;
    end else begin
      if (beat) begin
        if (beat_last) begin
          beat_cnt    <= '0;
          frames_sent <= frames_sent + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (gap_load) begin
        gap_cnt <= gap_q;
      end else if (gap_dec && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/md_burst_sequencer.sv
// Frames a free-running metadata generator into AXI-Stream bursts.
// FSM, handshake gating and burst status live here.
module md_burst_sequencer
  import md_pkg::*;
#(
  parameter int DW      = MD_DW,
  parameter int BEAT_W  = MD_BEAT_W,
  parameter int FRAME_W = MD_FRAME_W,
  parameter int GAP_W   = MD_GAP_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  input  logic [BEAT_W-1:0]  cfg_frame_beats,
  input  logic [FRAME_W-1:0] cfg_frame_count,
  input  logic [GAP_W-1:0]   cfg_gap_cycles,
  output logic               gen_start,
  input  logic [DW-1:0]      gen_tdata,
  input  logic               gen_tvalid,
  output logic               gen_tready,
  output logic [DW-1:0]      m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [FRAME_W-1:0] frames_sent
);

  state_t state;
  state_t nxt;

  logic abort_pend;
  logic start_ok;
  logic set_ab;
  logic beat;
  logic beat_last;
  logic frame_last;
  logic gap_last;
  logic gap_zero;
  logic stream;
  logic zero_cfg;

  assign stream   = (state == S_STREAM);
  assign zero_cfg = (cfg_frame_beats == '0) ||
                    (cfg_frame_count == '0);

  assign m_axis_tdata  = gen_tdata;
  assign m_axis_tvalid = stream & gen_tvalid;
  assign gen_tready    = stream & m_axis_tready;
  assign beat          = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast  = stream & beat_last;

  assign gen_start = (state == S_ARM);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  md_frame_counter #(
    .BEAT_W  (BEAT_W),
    .FRAME_W (FRAME_W),
    .GAP_W   (GAP_W)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (resetn),
    .load        (start_ok),
    .beat        (beat),
    .gap_load    (beat & beat_last),
    .gap_dec     (state == S_GAP),
    .cfg_beats   (cfg_frame_beats),
    .cfg_frames  (cfg_frame_count),
    .cfg_gap     (cfg_gap_cycles),
    .frames_sent (frames_sent),
    .beat_last   (beat_last),
    .frame_last  (frame_last),
    .gap_last    (gap_last),
    .gap_zero    (gap_zero)
  );

  // Next-state decode; set_ab marks a burst ending due to abort
  always_comb begin
    nxt      = state;
    start_ok = 1'b0;
    set_ab   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_start) begin
          start_ok = 1'b1;
          nxt      = zero_cfg ? S_DONE : S_ARM;
        end
      end
      S_ARM: begin
        if (cmd_abort) begin
          nxt    = S_DONE;
          set_ab = 1'b1;
        end else begin
          nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (beat && beat_last) begin
          if (frame_last || abort_pend || cmd_abort) begin
            nxt    = S_DONE;
            set_ab = abort_pend | cmd_abort;
          end else if (!gap_zero) begin
            nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cmd_abort) begin
          nxt    = S_DONE;
          set_ab = 1'b1;
        end else if (gap_last) begin
          nxt = S_STREAM;
        end
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nxt;
  end

  // Abort requested mid-frame waits for the frame boundary
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      abort_pend <= 1'b0;
    end else if (start_ok || state == S_DONE) begin
      abort_pend <= 1'b0;
    end else if (stream && cmd_abort) begin
      abort_pend <= 1'b1;
    end
  end

  // Sticky abort status, cleared by the next accepted burst
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aborted <= 1'b0;
    end else if (start_ok) begin
      aborted <= 1'b0;
    end else if (set_ab) begin
      aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_burst_sequencer.sv
// Self-checking bench for md_burst_sequencer.
// Burst table plus scoreboard of expected beats.
module tb_md_burst_sequencer;

  localparam int DW = 512;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cmd_start = 1'b0;
  logic              cmd_abort = 1'b0;
  logic [15:0]       cfg_frame_beats = '0;
  logic [15:0]       cfg_frame_count = '0;
  logic [7:0]        cfg_gap_cycles = '0;
  logic              gen_start;
  logic [DW-1:0]     gen_tdata;
  logic              gen_tvalid = 1'b0;
  logic              gen_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [15:0]       frames_sent;

  logic [31:0] gen_cnt = '0;
  logic        rnd_mode = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_beat_t;

  exp_beat_t sb[$];

  typedef struct {
    int beats;
    int frames;
    int gap;
    bit rnd;
    int abort_cyc;
    int poke_cyc;
    int exp_frames;
    int exp_ab;
    int exp_done;
  } vec_t;

  vec_t vecs[10];

  assign gen_tdata = {16{gen_cnt}};

  md_burst_sequencer dut (
    .clk             (clk),
    .resetn          (resetn),
    .cmd_start       (cmd_start),
    .cmd_abort       (cmd_abort),
    .cfg_frame_beats (cfg_frame_beats),
    .cfg_frame_count (cfg_frame_count),
    .cfg_gap_cycles  (cfg_gap_cycles),
    .gen_start       (gen_start),
    .gen_tdata       (gen_tdata),
    .gen_tvalid      (gen_tvalid),
    .gen_tready      (gen_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .frames_sent     (frames_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generator model and downstream ready
  always @(posedge clk) begin
    if (gen_tvalid && gen_tready) gen_cnt <= gen_cnt + 1;
    if (rnd_mode) begin
      if (!(gen_tvalid && !gen_tready))
        gen_tvalid <= 1'($urandom_range(0, 1));
      m_axis_tready <= 1'($urandom_range(0, 1));
    end else begin
      gen_tvalid    <= 1'b1;
      m_axis_tready <= 1'b1;
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int n;
    int t;
    int gs_cnt;
    int last_cnt;
    int prev_last;
    int exp_gs;
    bit got_done;
    exp_beat_t e;
    gs_cnt    = 0;
    last_cnt  = 0;
    prev_last = -1;
    got_done  = 0;
    t         = 0;
    exp_gs    = (v.beats != 0 && v.frames != 0) ? 1 : 0;
    @(negedge clk);
    rnd_mode        = v.rnd;
    cfg_frame_beats = 16'(v.beats);
    cfg_frame_count = 16'(v.frames);
    cfg_gap_cycles  = 8'(v.gap);
    cmd_start       = 1'b1;
    n               = cyc;
    for (int i = 0; i < v.exp_frames * v.beats; i++) begin
      e.data = gen_cnt + 32'(i);
      e.last = ((i % v.beats) == v.beats - 1);
      sb.push_back(e);
    end
    while (!got_done && t < 3000) begin
      @(negedge clk);
      t         = cyc - n;
      cmd_start = 1'b0;
      cmd_abort = (t == v.abort_cyc);
      if (t == v.poke_cyc) begin
        cmd_start       = 1'b1;
        cfg_frame_beats = 16'd1;
        cfg_frame_count = 16'd1;
        cfg_gap_cycles  = 8'd0;
      end
      if (gen_start) begin
        gs_cnt++;
        check("gen_start_cycle", 64'(t), 64'd1);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("extra_beat", 64'(t), 64'd0);
        end else begin
          e = sb.pop_front();
          check("beat_data",
                {m_axis_tdata[511:480], m_axis_tdata[31:0]},
                {e.data, e.data});
          check("beat_last", 64'(m_axis_tlast), 64'(e.last));
          if (!v.rnd && prev_last >= 0)
            check("gap_len", 64'(t - prev_last), 64'(v.gap + 1));
          prev_last = -1;
          if (m_axis_tlast) begin
            last_cnt++;
            prev_last = t;
          end
        end
      end
      if (done) got_done = 1;
    end
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    check("done_seen", 64'(got_done), 64'd1);
    if (v.exp_done > 0)
      check("done_cycle", 64'(t), 64'(v.exp_done));
    @(negedge clk);
    check("busy_after", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd0);
    check("frames_sent", 64'(frames_sent), 64'(v.exp_frames));
    check("aborted", 64'(aborted), 64'(v.exp_ab));
    check("beats_left", 64'(sb.size()), 64'd0);
    check("tlast_count", 64'(last_cnt), 64'(v.exp_frames));
    check("gen_start_count", 64'(gs_cnt), 64'(exp_gs));
    sb.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_gen_start"}, 64'(gen_start), 64'd0);
    check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
    check({tag, "_tready"}, 64'(gen_tready), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_aborted"}, 64'(aborted), 64'd0);
    check({tag, "_frames"}, 64'(frames_sent), 64'd0);
    check({tag, "_tdata"}, 64'(m_axis_tdata[63:0]),
          64'(gen_tdata[63:0]));
  endtask

  initial begin
    // beats frames gap rnd abort poke expF expAb doneAt
    vecs[0] = '{4, 3, 0, 0, -1, 5, 3, 0, 14};
    vecs[1] = '{2, 2, 3, 0, -1, -1, 2, 0, 9};
    vecs[2] = '{8, 4, 0, 1, -1, -1, 4, 0, 0};
    vecs[3] = '{5, 10, 0, 0, 8, -1, 2, 1, 12};
    vecs[4] = '{3, 2, 2, 1, -1, -1, 2, 0, 0};
    vecs[5] = '{1, 3, 1, 0, -1, -1, 3, 0, 7};
    vecs[6] = '{2, 3, 4, 0, 5, -1, 1, 1, 6};
    vecs[7] = '{4, 2, 0, 0, 1, -1, 0, 1, 2};
    vecs[8] = '{0, 3, 0, 0, -1, 1, 0, 0, 1};
    vecs[9] = '{3, 0, 0, 0, -1, 1, 0, 0, 1};

    #1;
    check_quiet("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) run_burst(vecs[i]);

    // Reset in the middle of a frame
    @(negedge clk);
    rnd_mode        = 1'b0;
    cfg_frame_beats = 16'd4;
    cfg_frame_count = 16'd2;
    cfg_gap_cycles  = 8'd0;
    cmd_start       = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_streaming", 64'(m_axis_tvalid), 64'd1);
    resetn = 1'b0;
    #1;
    check_quiet("midrst");
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();

    run_burst(vecs[1]);
    run_burst(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
